router_fifo: RTL
================

ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of 9-bit storage words; SHALL be a power of two.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 soft_reset  input  1  synchronous active-high flush of the current packet, issued by the controller on read timeout.
REQ-005 write_enb  input  1  write request from the controller.
REQ-006 read_enb  input  1  read request from the output port.
REQ-007 lfd_state  input  1  high while the header byte is presented on data_in; stored as word bit 8.
REQ-008 data_in  input  8  byte from the router register stage (header, payload or parity).
REQ-009 data_out  output  8  registered read byte.
REQ-010 full  output  1  high when count equals DEPTH.
REQ-011 empty  output  1  high when count equals 0.
REQ-012 pkt_done  output  1  one-cycle pulse when the last byte of a packet (parity) is read.

Function
REQ-013 Write: write_enb=1 and full=0 SHALL store {lfd_state,data_in} at wr_ptr, then increment wr_ptr modulo DEPTH.
REQ-014 Read: read_enb=1 and empty=0 SHALL load data_out with word[7:0] at rd_ptr on the same edge, then increment rd_ptr modulo DEPTH (latency 1 cycle).
REQ-015 Write with full=1 SHALL be dropped, even when a read occurs in the same cycle.
REQ-016 Read with empty=1 SHALL be ignored; data_out SHALL hold its value.
REQ-017 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-018 count SHALL be log2(DEPTH)+1 bits wide; full/empty SHALL be derived combinationally from count.
REQ-019 Read of a word with bit 8=1 SHALL load pkt_cnt with word[7:2]+1 (payload length plus parity).
REQ-020 Read of a word with bit 8=0 and pkt_cnt>0 SHALL decrement pkt_cnt.
REQ-021 pkt_done SHALL pulse on the cycle after the read that moves pkt_cnt from 1 to 0.
REQ-022 Header with length field 0 SHALL load pkt_cnt=1; the next read (parity) completes the packet.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0 without a gap.
REQ-024 When pkt_cnt=0 and empty=1, data_out SHALL be driven 8'h00 on the next edge.

Reset
REQ-025 reset=1 SHALL clear wr_ptr, rd_ptr, count, pkt_cnt, data_out and pkt_done; full=0, empty=1.
REQ-026 soft_reset=1 SHALL have the same effect as reset; memory contents need not be cleared.
REQ-027 reset/soft_reset SHALL take priority over simultaneous read/write; the concurrent write SHALL be lost.

Configuration
REQ-028 With ROUTER_FIFO_ERR_FLAG_EN defined: output err_flag (1 bit) SHALL set sticky on a dropped write (REQ-015) or ignored read (REQ-016), cleared only by reset or soft_reset.
REQ-029 Without ROUTER_FIFO_ERR_FLAG_EN: err_flag port and its logic SHALL be absent.

Structure
REQ-030 Package router_pkg SHALL hold FIFO_DEPTH=16, WORD_W=9, HDR_BIT=8, and the header length-field slice bounds.
REQ-031 One sub-module, router_fifo_mem (DEPTH x 9 synchronous-write, combinational-read array), SHALL hold storage; pointers and counters stay in router_fifo.

Verification
REQ-032 Reset, then write header 8'h0E (lfd=1), 3 payload bytes, parity; read 5 -> data_out matches in order, pkt_done pulses once after 5th read, empty=1.
REQ-033 16 writes without reads -> full=1 after 16th; 17th write dropped; 16 reads return the first 16 bytes.
REQ-034 From full, assert write_enb and read_enb together -> write dropped, count 15; from count 8, both -> count stays 8.
REQ-035 Write 3 words, assert soft_reset mid-read -> empty=1, data_out=0, pkt_cnt=0 next cycle; new packet then reads correctly.
REQ-036 Write/read 40 bytes streaming (pointer wrap twice) -> data in order, no loss, count never exceeds 16.
REQ-037 With ROUTER_FIFO_ERR_FLAG_EN: read while empty -> err_flag=1 until reset; without macro, build has no err_flag.

Source files
------------

// File: rtl/router_fifo_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared constants and helpers for the router FIFO slice.
//   FIFO_DEPTH      default number of storage words
//   WORD_W          stored word width: {header flag, data byte}
//   HDR_BIT         position of the header flag inside a stored word
//   LEN_MSB/LEN_LSB payload length field inside a header byte
//   PKT_CNT_W       width of the per-packet byte counter
//   hdr_pkt_len()   bytes still to read after a header (payload + parity)
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int WORD_W     = 9;
  localparam int HDR_BIT    = 8;
  localparam int LEN_MSB    = 7;
  localparam int LEN_LSB    = 2;

  // One extra bit so the largest length (63) plus the parity byte still fits.
  localparam int PKT_CNT_W  = LEN_MSB - LEN_LSB + 2;

  typedef logic [WORD_W-1:0] fifo_word_t;

  function automatic logic [PKT_CNT_W-1:0] hdr_pkt_len(input fifo_word_t word);
    return PKT_CNT_W'(word[LEN_MSB:LEN_LSB]) + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// ---------------------------------------------------------------------------
// router_fifo_if
// Bundles the FIFO's controller/output-port signals.
//   soft_reset, write_enb, read_enb, lfd_state, data_in : into the FIFO
//   data_out, full, empty, pkt_done                     : out of the FIFO
//   err_flag (only with ROUTER_FIFO_ERR_FLAG_EN)         : out of the FIFO
// Modports: master = the side driving requests, slave = the FIFO itself.
// ---------------------------------------------------------------------------
interface router_fifo_if;

  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       pkt_done;

`ifdef ROUTER_FIFO_ERR_FLAG_EN
  logic       err_flag;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty, pkt_done, err_flag
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty, pkt_done, err_flag
  );
`else
  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty, pkt_done
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty, pkt_done
  );
`endif

endinterface

// File: rtl/router_fifo_mem.sv
// ---------------------------------------------------------------------------
// router_fifo_mem
// DEPTH x WORD_W storage array: synchronous write, combinational read.
//   clock    : write clock
//   wr_en    : write strobe (already qualified by the caller)
//   wr_addr  : write address
//   wr_data  : word to store
//   rd_addr  : read address
//   rd_data  : word at rd_addr, available in the same cycle
// Contents are not reset; occupancy is tracked by the parent.
// ---------------------------------------------------------------------------
module router_fifo_mem
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fifo_word_t    wr_data,
  input  logic [AW-1:0] rd_addr,
  output fifo_word_t    rd_data
);

  fifo_word_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// ---------------------------------------------------------------------------
// router_fifo
// Packet-aware FIFO for one router output port. Each stored word is
// {lfd_state, data_in}; the header flag lets the read side track packet
// boundaries and pulse pkt_done when a packet's parity byte leaves.
//   clock      : single clock, all state on its rising edge
//   reset      : synchronous active-high reset
//   bus.slave  : soft_reset, write_enb, read_enb, lfd_state, data_in in;
//                data_out (registered), full, empty, pkt_done out
// Optional feature macro: ROUTER_FIFO_ERR_FLAG_EN adds bus.err_flag, a
// sticky flag for dropped writes and ignored reads.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  router_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic [7:0]           data_out_q;
  logic                 pkt_done_q;
  fifo_word_t           rd_word;
  logic                 flush;
  logic                 wr_accept;
  logic                 rd_accept;

  // Both resets behave identically; memory contents are left alone.
  assign flush = reset | bus.soft_reset;

  assign bus.full  = (count == CW'(DEPTH));
  assign bus.empty = (count == '0);

  // A full FIFO drops the write even if a read frees a slot this cycle.
  assign wr_accept = bus.write_enb & ~bus.full;
  assign rd_accept = bus.read_enb & ~bus.empty;

  router_fifo_mem #(
    .DEPTH   (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_accept & ~flush),
    .wr_addr (wr_ptr),
    .wr_data ({bus.lfd_state, bus.data_in}),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Read side: a header reloads the packet counter with payload + parity;
  // every later byte counts down and the byte taking it 1 -> 0 is the
  // parity, which raises pkt_done for the following cycle. Once the packet
  // is finished and nothing is left, data_out is returned to zero.
  always_ff @(posedge clock) begin
    if (flush) begin
      data_out_q <= '0;
      pkt_cnt    <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      if (rd_accept) begin
        data_out_q <= rd_word[HDR_BIT-1:0];
        if (rd_word[HDR_BIT]) begin
          pkt_cnt <= hdr_pkt_len(rd_word);
        end else if (pkt_cnt != '0) begin
          pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
          if (pkt_cnt == PKT_CNT_W'(1)) begin
            pkt_done_q <= 1'b1;
          end
        end
      end else if ((pkt_cnt == '0) && bus.empty) begin
        data_out_q <= '0;
      end
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.pkt_done = pkt_done_q;

`ifdef ROUTER_FIFO_ERR_FLAG_EN
  logic err_q;

  // Sticky record of any request the FIFO had to refuse.
  always_ff @(posedge clock) begin
    if (flush) begin
      err_q <= 1'b0;
    end else if ((bus.write_enb & bus.full) | (bus.read_enb & bus.empty)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_flag = err_q;
`endif

endmodule
